// File: rtl/bullet_pkg.sv
// rtl/bullet_pkg.sv - shared bullet slot record, colour codes and field defaults
// Contents: slot_t record (active, x, y, w, h, color, dy) at default widths,
//           colour constants, default boundary/wrap rows.
package bullet_pkg;

    localparam int COORD_W_DEF = 8;
    localparam int DY_W_DEF    = 4;
    localparam int Y_MAX_DEF   = 200;
    localparam int Y_WRAP_DEF  = 1;

    localparam logic [2:0] WHITE = 3'd0;
    localparam logic [2:0] GREEN = 3'd1;
    localparam logic [2:0] BLUE  = 3'd2;

    typedef struct packed {
        logic                   active;
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic [COORD_W_DEF-1:0] w;
        logic [COORD_W_DEF-1:0] h;
        logic [2:0]             color;
        logic [DY_W_DEF-1:0]    dy;
    } slot_t;

endpackage

// File: rtl/bullet_pool_if.sv
// rtl/bullet_pool_if.sv - control, spawn, read-port and hit bundle of the bullet pool
// master: game logic / renderer side (drives run, clear, spawn_*, *_idx, hit_valid)
// slave : bullet_pool (drives spawn_ready, spawn_slot, vga_*, hit_x/y/w/h/color/active, live_count)
interface bullet_pool_if #(
    parameter int COORD_W = 8,
    parameter int DY_W    = 4,
    parameter int IDX_W   = 3
);
    logic               run;
    logic               clear;
    logic               spawn_valid;
    logic               spawn_ready;
    logic [COORD_W-1:0] spawn_x;
    logic [COORD_W-1:0] spawn_y;
    logic [COORD_W-1:0] spawn_w;
    logic [COORD_W-1:0] spawn_h;
    logic [2:0]         spawn_color;
    logic [DY_W-1:0]    spawn_dy;
    logic [IDX_W-1:0]   spawn_slot;
    logic [IDX_W-1:0]   vga_idx;
    logic [COORD_W-1:0] vga_x;
    logic [COORD_W-1:0] vga_y;
    logic [COORD_W-1:0] vga_w;
    logic [COORD_W-1:0] vga_h;
    logic [2:0]         vga_color;
    logic               vga_active;
    logic [IDX_W-1:0]   hit_idx;
    logic [COORD_W-1:0] hit_x;
    logic [COORD_W-1:0] hit_y;
    logic [COORD_W-1:0] hit_w;
    logic [COORD_W-1:0] hit_h;
    logic [2:0]         hit_color;
    logic               hit_active;
    logic               hit_valid;
    logic [IDX_W:0]     live_count;

    modport master (
        output run, clear, spawn_valid, spawn_x, spawn_y, spawn_w, spawn_h,
               spawn_color, spawn_dy, vga_idx, hit_idx, hit_valid,
        input  spawn_ready, spawn_slot, vga_x, vga_y, vga_w, vga_h, vga_color,
               vga_active, hit_x, hit_y, hit_w, hit_h, hit_color, hit_active,
               live_count
    );

    modport slave (
        input  run, clear, spawn_valid, spawn_x, spawn_y, spawn_w, spawn_h,
               spawn_color, spawn_dy, vga_idx, hit_idx, hit_valid,
        output spawn_ready, spawn_slot, vga_x, vga_y, vga_w, vga_h, vga_color,
               vga_active, hit_x, hit_y, hit_w, hit_h, hit_color, hit_active,
               live_count
    );
endinterface

// File: rtl/bullet_alloc.sv
// rtl/bullet_alloc.sv - lowest-free-slot priority encoder for bullet spawns
// active      in : per-slot active flags
// clear       in : pool clear in progress (blocks spawning)
// spawn_slot  out: lowest inactive slot index (0 when the pool is full)
// spawn_ready out: some slot is free and no clear is in progress
module bullet_alloc #(
    parameter int NUM_SLOTS = 8,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_SLOTS-1:0] active,
    input  logic                 clear,
    output logic [IDX_W-1:0]     spawn_slot,
    output logic                 spawn_ready
);
    always_comb begin
        spawn_slot = '0;
        // Scan downward so the lowest free index is the last one written.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active[i]) spawn_slot = IDX_W'(i);
        end
        spawn_ready = !(&active) && !clear;
    end
endmodule

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - bullet slot store with spawn, tick-driven motion, boundary wrap/retire and hit clear
// clk, rst : system clock, asynchronous active-high reset
// bus      : bullet_pool_if slave (run/clear, spawn handshake, two combinational
//            read ports, hit report, live_count)
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int DY_W      = DY_W_DEF,
    parameter int Y_MAX     = Y_MAX_DEF,
    parameter int Y_WRAP    = Y_WRAP_DEF,
    parameter bit WRAP_MODE = 1'b1,
    parameter int TICK_DIV  = 4,
    parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    bullet_pool_if.slave      bus
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef struct packed {
        logic               active;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [2:0]         color;
        logic [DY_W-1:0]    dy;
    } rec_t;

    rec_t             slots [NUM_SLOTS];
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [NUM_SLOTS-1:0] act_vec;
    logic [IDX_W-1:0] alloc_slot;
    logic             alloc_ready;
    logic             spawn_fire;
    logic [COORD_W:0] ny    [NUM_SLOTS];
    logic             at_bound [NUM_SLOTS];

    assign tick       = bus.run && (div_cnt == DIV_W'(TICK_DIV - 1));
    assign spawn_fire = bus.spawn_valid && alloc_ready;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            act_vec[i] = slots[i].active;
            // One extra bit so a step past the top of the coordinate range
            // still registers as reaching the boundary.
            ny[i]       = {1'b0, slots[i].y} + (COORD_W+1)'(slots[i].dy);
            at_bound[i] = (ny[i] >= (COORD_W+1)'(Y_MAX));
        end
    end

    bullet_alloc #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_alloc (
        .active      (act_vec),
        .clear       (bus.clear),
        .spawn_slot  (alloc_slot),
        .spawn_ready (alloc_ready)
    );

    assign bus.spawn_slot  = alloc_slot;
    assign bus.spawn_ready = alloc_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (bus.clear) begin
            div_cnt <= '0;
        end else if (bus.run) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    // Per-slot priority: clear > hit > spawn > motion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (bus.clear) begin
                    slots[i] <= '0;
                end else if (bus.hit_valid && bus.hit_idx == IDX_W'(i)) begin
                    slots[i].active <= 1'b0;
                end else if (spawn_fire && alloc_slot == IDX_W'(i)) begin
                    slots[i].active <= 1'b1;
                    slots[i].x      <= bus.spawn_x;
                    slots[i].y      <= bus.spawn_y;
                    slots[i].w      <= bus.spawn_w;
                    slots[i].h      <= bus.spawn_h;
                    slots[i].color  <= bus.spawn_color;
                    slots[i].dy     <= bus.spawn_dy;
                end else if (tick && slots[i].active) begin
                    if (at_bound[i]) begin
                        if (WRAP_MODE) slots[i].y      <= COORD_W'(Y_WRAP);
                        else           slots[i].active <= 1'b0;
                    end else begin
                        slots[i].y <= ny[i][COORD_W-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.live_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            bus.live_count = bus.live_count + {{IDX_W{1'b0}}, slots[i].active};
        end
    end

    // Index matching only in-range slots leaves out-of-range reads at zero.
    always_comb begin
        bus.vga_x = '0; bus.vga_y = '0; bus.vga_w = '0; bus.vga_h = '0;
        bus.vga_color = '0; bus.vga_active = 1'b0;
        bus.hit_x = '0; bus.hit_y = '0; bus.hit_w = '0; bus.hit_h = '0;
        bus.hit_color = '0; bus.hit_active = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.vga_idx == IDX_W'(i)) begin
                bus.vga_x      = slots[i].x;
                bus.vga_y      = slots[i].y;
                bus.vga_w      = slots[i].w;
                bus.vga_h      = slots[i].h;
                bus.vga_color  = slots[i].color;
                bus.vga_active = slots[i].active;
            end
            if (bus.hit_idx == IDX_W'(i)) begin
                bus.hit_x      = slots[i].x;
                bus.hit_y      = slots[i].y;
                bus.hit_w      = slots[i].w;
                bus.hit_h      = slots[i].h;
                bus.hit_color  = slots[i].color;
                bus.hit_active = slots[i].active;
            end
        end
    end
endmodule

// File: tb/tb_bullet_pool.sv
// tb/tb_bullet_pool.sv - directed table-driven bench for bullet_pool (wrap and retire builds)
module tb_bullet_pool;
    import bullet_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bullet_pool_if #(.COORD_W(8), .DY_W(4), .IDX_W(3)) bw ();
    bullet_pool_if #(.COORD_W(8), .DY_W(4), .IDX_W(3)) br ();

    bullet_pool #(.NUM_SLOTS(8), .COORD_W(8), .DY_W(4), .Y_MAX(200), .Y_WRAP(1),
                  .WRAP_MODE(1'b1), .TICK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bw.slave));
    bullet_pool #(.NUM_SLOTS(8), .COORD_W(8), .DY_W(4), .Y_MAX(200), .Y_WRAP(1),
                  .WRAP_MODE(1'b0), .TICK_DIV(4)) dut_r (.clk(clk), .rst(rst), .bus(br.slave));

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit sv; int x; int y; int dy; int c;
        bit hv; int hi; bit clr;
        int ridx; bit e_act; int e_y; int e_x; int e_c; int e_live; int e_slot; bit e_rdy;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_w();
        bw.spawn_valid = 1'b0; bw.hit_valid = 1'b0; bw.clear = 1'b0;
    endtask

    task automatic idle_r();
        br.spawn_valid = 1'b0; br.hit_valid = 1'b0; br.clear = 1'b0;
    endtask

    task automatic rd(input int i);
        bw.vga_idx = 3'(i);
        bw.hit_idx = 3'(i);
        #1;
    endtask

    task automatic spawn_w(input int x, input int y, input int dy, input int c);
        bw.spawn_valid = 1'b1;
        bw.spawn_x = 8'(x); bw.spawn_y = 8'(y); bw.spawn_w = 8'd16; bw.spawn_h = 8'd16;
        bw.spawn_color = 3'(c); bw.spawn_dy = 4'(dy);
    endtask

    int exp_fill [6];

    initial begin
        bw.run = 0; bw.vga_idx = 0; bw.hit_idx = 0;
        spawn_w(0, 0, 0, 0); idle_w();
        br.run = 0; br.vga_idx = 0; br.hit_idx = 0;
        br.spawn_x = 0; br.spawn_y = 0; br.spawn_w = 0; br.spawn_h = 0;
        br.spawn_color = 0; br.spawn_dy = 0; idle_r();

        //         sv  x   y   dy c             hv hi clr  ridx act y   x   c  live slot rdy
        vecs[0] = '{1, 16, 160, 5, int'(GREEN), 0, 0, 0,   0,   1, 160, 16, 1, 1,   1,   1};
        vecs[1] = '{1, 30, 10,  1, int'(BLUE),  0, 0, 0,   1,   1, 10,  30, 2, 2,   2,   1};
        vecs[2] = '{1, 40, 20,  0, int'(WHITE), 0, 0, 0,   2,   1, 20,  40, 0, 3,   3,   1};
        vecs[3] = '{0, 0,  0,   0, 0,           1, 1, 0,   1,   0, 10,  30, 2, 2,   1,   1};
        vecs[4] = '{1, 50, 50,  2, 2,           0, 0, 0,   1,   1, 50,  50, 2, 3,   3,   1};
        vecs[5] = '{1, 60, 60,  1, 1,           0, 0, 1,   0,   0, 0,   0,  0, 0,   0,   1};
        vecs[6] = '{1, 16, 160, 5, 1,           0, 0, 0,   0,   1, 160, 16, 1, 1,   1,   1};
        vecs[7] = '{1, 70, 198, 5, 2,           0, 0, 0,   1,   1, 198, 70, 2, 2,   2,   1};
        vecs[8] = '{1, 80, 20,  0, 0,           0, 0, 0,   2,   1, 20,  80, 0, 3,   3,   1};
        vecs[9] = '{0, 0,  0,   0, 0,           1, 5, 0,   5,   0, 0,   0,  0, 3,   3,   1};
        exp_fill = '{0, 3, 4, 5, 6, 7};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        rd(0);
        chk("reset_live", int'(bw.live_count), 0);
        chk("reset_ready", int'(bw.spawn_ready), 1);
        chk("reset_slot", int'(bw.spawn_slot), 0);
        chk("reset_vga_active", int'(bw.vga_active), 0);
        chk("reset_vga_y", int'(bw.vga_y), 0);
        chk("reset_hit_color", int'(bw.hit_color), 0);

        for (int k = 0; k < 10; k++) begin
            if (vecs[k].sv) spawn_w(vecs[k].x, vecs[k].y, vecs[k].dy, vecs[k].c);
            bw.hit_valid = vecs[k].hv;
            bw.hit_idx   = 3'(vecs[k].hi);
            bw.clear     = vecs[k].clr;
            step();
            idle_w();
            rd(vecs[k].ridx);
            chk($sformatf("v%0d_active", k), int'(bw.vga_active), int'(vecs[k].e_act));
            chk($sformatf("v%0d_vga_y", k), int'(bw.vga_y), vecs[k].e_y);
            chk($sformatf("v%0d_hit_y", k), int'(bw.hit_y), vecs[k].e_y);
            chk($sformatf("v%0d_x", k), int'(bw.vga_x), vecs[k].e_x);
            chk($sformatf("v%0d_color", k), int'(bw.hit_color), vecs[k].e_c);
            chk($sformatf("v%0d_live", k), int'(bw.live_count), vecs[k].e_live);
            chk($sformatf("v%0d_slot", k), int'(bw.spawn_slot), vecs[k].e_slot);
            chk($sformatf("v%0d_ready", k), int'(bw.spawn_ready), int'(vecs[k].e_rdy));
        end

        // Motion: slot0 y160 dy5, slot1 y198 dy5 (wraps), slot2 y20 dy0.
        bw.run = 1'b1;
        repeat (3) step();
        rd(0); chk("mot_before_tick_y0", int'(bw.vga_y), 160);
        step();
        rd(0); chk("mot_tick1_y0", int'(bw.vga_y), 165);
        rd(1); chk("mot_wrap_y1", int'(bw.vga_y), 1);
        chk("mot_wrap_active1", int'(bw.vga_active), 1);
        rd(2); chk("mot_dy0_y2", int'(bw.vga_y), 20);
        repeat (4) step();
        rd(0); chk("mot_tick2_y0", int'(bw.vga_y), 170);
        rd(1); chk("mot_tick2_y1", int'(bw.vga_y), 6);
        bw.run = 1'b0;
        repeat (8) step();
        rd(0); chk("freeze_y0", int'(bw.vga_y), 170);
        rd(1); chk("freeze_y1", int'(bw.vga_y), 6);

        // Hit on slot0 in the same cycle as a tick.
        bw.run = 1'b1;
        repeat (3) step();
        bw.hit_valid = 1'b1; bw.hit_idx = 3'd0;
        step();
        idle_w(); bw.run = 1'b0;
        rd(0);
        chk("hit_tick_active0", int'(bw.vga_active), 0);
        chk("hit_tick_y0", int'(bw.vga_y), 170);
        rd(1); chk("hit_tick_y1", int'(bw.vga_y), 11);
        chk("hit_tick_live", int'(bw.live_count), 2);

        // Fill remaining slots in lowest-free order.
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fill%0d_slot", k), int'(bw.spawn_slot), exp_fill[k]);
            chk($sformatf("fill%0d_ready", k), int'(bw.spawn_ready), 1);
            spawn_w(90, 40 + k, 0, 0);
            step();
            idle_w();
        end
        chk("full_live", int'(bw.live_count), 8);
        chk("full_ready", int'(bw.spawn_ready), 0);
        spawn_w(90, 99, 0, 0);
        step();
        idle_w();
        rd(0);
        chk("full_ignored_live", int'(bw.live_count), 8);
        chk("full_ignored_y0", int'(bw.vga_y), 40);
        bw.hit_valid = 1'b1; bw.hit_idx = 3'd3;
        step();
        idle_w();
        chk("refree_ready", int'(bw.spawn_ready), 1);
        chk("refree_slot", int'(bw.spawn_slot), 3);
        chk("refree_live", int'(bw.live_count), 7);

        // Retire build: y198 dy5 leaves the field, y100 dy5 moves.
        br.spawn_valid = 1'b1; br.spawn_y = 8'd198; br.spawn_dy = 4'd5;
        step();
        br.spawn_y = 8'd100;
        step();
        idle_r();
        chk("ret_live_before", int'(br.live_count), 2);
        br.run = 1'b1;
        repeat (4) step();
        br.run = 1'b0;
        br.vga_idx = 3'd0; #1;
        chk("ret_active0", int'(br.vga_active), 0);
        chk("ret_y0", int'(br.vga_y), 198);
        chk("ret_live_after", int'(br.live_count), 1);
        br.vga_idx = 3'd1; #1;
        chk("ret_y1", int'(br.vga_y), 105);

        // Asynchronous reset between edges.
        step();
        rd(1);
        #1 rst = 1'b1;
        #1;
        chk("arst_live", int'(bw.live_count), 0);
        chk("arst_ready", int'(bw.spawn_ready), 1);
        chk("arst_slot", int'(bw.spawn_slot), 0);
        chk("arst_vga_y", int'(bw.vga_y), 0);
        chk("arst_active", int'(bw.vga_active), 0);
        chk("arst_r_live", int'(br.live_count), 0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bullet_pool.md
# bullet_pool

Parametrised bullet store and motion engine for the game field. Holds `NUM_SLOTS` bullet slots (position, size, colour, per-slot vertical speed, active flag); accepts new bullets through a valid/ready spawn port, advances active bullets on an internal movement tick, and retires or wraps them at the field boundary. Serves two independent combinational read ports (VGA renderer, collision/damage path) and clears a slot on a reported hit.

## Interface
- `NUM_SLOTS`, 8: number of bullet slots (2..16).
- `COORD_W`, 8: width of x, y, w, h.
- `DY_W`, 4: width of per-slot speed (unsigned, pixels per tick).
- `Y_MAX`, 200: lower field boundary; y reaching or passing it triggers the boundary action.
- `Y_WRAP`, 1: y loaded on wrap.
- `WRAP_MODE`, 1: 1 = wrap to `Y_WRAP` and stay active, 0 = retire (active cleared).
- `TICK_DIV`, 4: clock cycles per movement tick (≥1).
- `IDX_W`, `$clog2(NUM_SLOTS)`: slot index width (derived).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: 1 = motion enabled; 0 = freeze positions and tick divider.
- `clear` in 1: synchronous clear of all slots and divider.
- `spawn_valid` in 1 / `spawn_ready` out 1: spawn handshake.
- `spawn_x`, `spawn_y`, `spawn_w`, `spawn_h` in `COORD_W` each; `spawn_color` in 3; `spawn_dy` in `DY_W`.
- `spawn_slot` out `IDX_W`: slot the next accepted spawn will occupy (lowest free index).
- `vga_idx` in `IDX_W`; `vga_x`, `vga_y`, `vga_w`, `vga_h` out `COORD_W`; `vga_color` out 3; `vga_active` out 1.
- `hit_idx` in `IDX_W`; `hit_x`, `hit_y`, `hit_w`, `hit_h` out `COORD_W`; `hit_color` out 3; `hit_active` out 1.
- `hit_valid` in 1: collision reported against slot `hit_idx` this cycle.
- `live_count` out `IDX_W+1`: number of active slots.

## Operation
- Slot fields: active, x, y, w, h, color, dy. Reset/clear: all fields 0, so every read output 0, `live_count` 0, `spawn_ready` 1, `spawn_slot` 0.
- Read ports: purely combinational from the slot array; index ≥ `NUM_SLOTS` returns all zeros.
- Spawn: `spawn_ready` = any slot inactive and `clear` low. On `spawn_valid && spawn_ready` the slot `spawn_slot` is loaded with the inputs and active set. Accepted regardless of `run`.
- Tick divider: counts 0..`TICK_DIV`-1 while `run`=1; `tick` asserted on the cycle count = `TICK_DIV`-1; holds while `run`=0.
- Motion on `tick`: for each active slot, `ny = y + dy` computed in `COORD_W+1` bits; if `ny ≥ Y_MAX` apply boundary action (wrap: y ← `Y_WRAP`; retire: active ← 0, y unchanged), else y ← `ny[COORD_W-1:0]`. x never changes. dy = 0 is stationary.
- Hit: on `hit_valid`, slot `hit_idx` active ← 0; other fields retained. Hit on an inactive or out-of-range slot is a no-op.
- Priority per slot per cycle: `clear` > hit > spawn > motion. A slot cleared by hit is not re-spawned in the same cycle (spawn_slot is computed from pre-edge state, so it is never the slot being hit unless that slot was already free).
- `live_count` reflects registered state (updates the cycle after any change).

## Timing
- Reads: zero latency, combinational from registers.
- Spawn: slot readable with active=1 on the cycle after acceptance; `spawn_slot`/`spawn_ready` update the same cycle.
- Hit: active=0 visible the cycle after `hit_valid`.
- Motion: first tick `TICK_DIV` cycles after `run` rises from a zero divider; one step per tick.
- `rst` mid-operation: all state to reset values immediately, independent of `clk`.

## Structure
- Shared package `bullet_pkg`: slot record typedef (active, x, y, w, h, color, dy), colour constants (WHITE=0, GREEN=1, BLUE=2), default `Y_MAX`/`Y_WRAP`.
- One sub-module: `bullet_alloc` — lowest-free-index priority encoder producing `spawn_slot` and `spawn_ready` from the active vector.

## Test plan
- Reset, then spawn x=16,y=160,w=16,h=16,color=1,dy=5 → slot 0 active next cycle, `live_count`=1, `spawn_slot`=1.
- `run`=1, `TICK_DIV`=4, y=160,dy=5 → y=165 after 4 cycles, 170 after 8; `run`=0 freezes y.
- WRAP_MODE=1, y=198,dy=5 → next tick y=1 active; WRAP_MODE=0 same → active=0, `live_count` decrements.
- Fill all 8 slots → `spawn_ready`=0, further `spawn_valid` ignored; hit slot 3 → next cycle `spawn_ready`=1, `spawn_slot`=3.
- Same cycle: `hit_valid` on slot 2 and tick → slot 2 inactive, y unchanged; `clear` with `spawn_valid` → all slots empty, spawn dropped.
- Assert `rst` asynchronously between edges with slots active → all outputs zero before next `clk` edge.
